vec_csr_ctrl: RTL and testbench

VEC_CSR_CTRL -- requirements
Module: vec_csr_ctrl

---
 rtl/vec_csr_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_vec_csr_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_csr_ctrl.sv
// vec_csr_ctrl: vector CSR and configuration controller.
//
// Serves two kinds of requests through a single valid/ready handshake:
//   - CSR accesses (csrrw/rs/rc and their immediate forms) to vstart,
//     vxsat, vxrm, vcsr, vl, vtype and vlenb. The update lands on the
//     accept edge, and the response follows one cycle later.
//   - Configuration requests (vsetvli, vsetivli, vsetvl). These wait until
//     the vector pipeline drains (vec_idle), then commit vtype/vl/vlmax,
//     clear vstart and respond with the new vl.
//
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_kind            00 CSR, 01 vsetvli, 10 vsetivli, 11 vsetvl
//   req_funct3          CSR operation encoding
//   req_csr_addr        CSR address
//   req_rs1_addr        rs1 index (uimm field for immediate forms)
//   req_rd_addr         rd index
//   req_src             rs1 value, AVL or zero-extended uimm
//   req_vtype           proposed vtype for configuration requests
//   vec_idle            vector pipeline empty
//   vxsat_set           saturation event from the datapath
//   resp_valid          one-cycle response strobe
//   resp_data           old CSR value or new vl
//   resp_illegal        request was illegal
//   vtype_o, vl_o, vstart_o, vlmax_o, sew_o, vxrm_o, vill_o
//                       current architectural state
module vec_csr_ctrl #(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int ELEN = 64
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_csr_addr,
    input  logic [4:0]      req_rs1_addr,
    input  logic [4:0]      req_rd_addr,
    input  logic [XLEN-1:0] req_src,
    input  logic [XLEN-1:0] req_vtype,
    input  logic            vec_idle,
    input  logic            vxsat_set,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_illegal,
    output logic [XLEN-1:0] vtype_o,
    output logic [XLEN-1:0] vl_o,
    output logic [XLEN-1:0] vstart_o,
    output logic [XLEN-1:0] vlmax_o,
    output logic [6:0]      sew_o,
    output logic [1:0]      vxrm_o,
    output logic            vill_o
);

    localparam int VSTART_W = $clog2(VLEN);
    localparam int ELEN_LOG = $clog2(ELEN);

    localparam logic [XLEN-1:0] VLEN_X     = XLEN'(VLEN);
    localparam logic [XLEN-1:0] VLENB_X    = XLEN'(VLEN / 8);
    localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [11:0] CSR_VSTART = 12'h008;
    localparam logic [11:0] CSR_VXSAT  = 12'h009;
    localparam logic [11:0] CSR_VXRM   = 12'h00A;
    localparam logic [11:0] CSR_VCSR   = 12'h00F;
    localparam logic [11:0] CSR_VL     = 12'hC20;
    localparam logic [11:0] CSR_VTYPE  = 12'hC21;
    localparam logic [11:0] CSR_VLENB  = 12'hC22;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_RESP      = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]     vtype_q, vtype_d;
    logic [XLEN-1:0]     vl_q, vl_d;
    logic [XLEN-1:0]     vlmax_q, vlmax_d;
    logic [VSTART_W-1:0] vstart_q, vstart_d;
    logic [1:0]          vxrm_q, vxrm_d;
    logic                vxsat_q, vxsat_d;
    logic [XLEN-1:0]     resp_data_q, resp_data_d;
    logic                resp_illegal_q, resp_illegal_d;

    // Configuration request captured at accept; the request bus is free to
    // change while the pipeline drains.
    logic                pend_ivli_q, pend_ivli_d;
    logic                pend_rs1_zero_q, pend_rs1_zero_d;
    logic                pend_rd_zero_q, pend_rd_zero_d;
    logic [XLEN-1:0]     pend_src_q, pend_src_d;
    logic [XLEN-2:0]     pend_vtype_q, pend_vtype_d;

    logic accept_csr;
    logic accept_cfg;
    logic commit_cfg;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_csr) begin
                    state_d = ST_RESP;
                end else if (accept_cfg) begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (vec_idle) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
    end

    assign accept_csr = req_valid && req_ready && (req_kind == 2'b00);
    assign accept_cfg = req_valid && req_ready && (req_kind != 2'b00);
    assign commit_cfg = (state_q == ST_WAIT_IDLE) && vec_idle;

    // ------------------------------------------------------------------
    // CSR decode
    // ------------------------------------------------------------------
    logic            csr_known;
    logic            csr_ro;
    logic            csr_illegal;
    logic [XLEN-1:0] csr_old;
    logic [XLEN-1:0] csr_new;

    always_comb begin
        csr_known = 1'b1;
        csr_ro    = 1'b0;
        csr_old   = '0;
        case (req_csr_addr)
            CSR_VSTART: csr_old = XLEN'(vstart_q);
            CSR_VXSAT:  csr_old = XLEN'(vxsat_q);
            CSR_VXRM:   csr_old = XLEN'(vxrm_q);
            CSR_VCSR:   csr_old = XLEN'({vxrm_q, vxsat_q});
            CSR_VL: begin
                csr_ro  = 1'b1;
                csr_old = vl_q;
            end
            CSR_VTYPE: begin
                csr_ro  = 1'b1;
                csr_old = vtype_q;
            end
            CSR_VLENB: begin
                csr_ro  = 1'b1;
                csr_old = VLENB_X;
            end
            default: csr_known = 1'b0;
        endcase

        // Set/clear forms of read-only CSRs are plain reads when rs1 is x0;
        // any other attempt to modify them is rejected.
        csr_illegal = !csr_known
                   || (req_funct3 == 3'b000) || (req_funct3 == 3'b100)
                   || (csr_ro && ((req_funct3[1:0] == 2'b01)
                                  || (req_rs1_addr != 5'd0)));

        case (req_funct3[1:0])
            2'b01:   csr_new = req_src;
            2'b10:   csr_new = csr_old | req_src;
            2'b11:   csr_new = csr_old & ~req_src;
            default: csr_new = csr_old;
        endcase
    end

    // ------------------------------------------------------------------
    // vtype legality, VLMAX and new vl for the pending config request.
    // Everything is worked in log2 so VLMAX needs only shifts.
    // ------------------------------------------------------------------
    logic [2:0]      cfg_vlmul;
    logic [2:0]      cfg_vsew;
    logic            cfg_frac;
    logic [4:0]      cfg_lsew;
    logic [4:0]      cfg_frac_sh;
    logic            cfg_ill;
    logic [XLEN-1:0] cfg_base;
    logic [XLEN-1:0] cfg_vlmax;
    logic [XLEN-1:0] cfg_vl;
    logic [XLEN-1:0] cfg_vtype;

    always_comb begin
        cfg_vlmul   = pend_vtype_q[2:0];
        cfg_vsew    = pend_vtype_q[5:3];
        cfg_frac    = cfg_vlmul[2];
        cfg_lsew    = {2'b00, cfg_vsew} + 5'd3;
        // 101 -> 3, 110 -> 2, 111 -> 1: log2 of the LMUL divisor
        cfg_frac_sh = 5'd8 - {2'b00, cfg_vlmul};

        cfg_ill = (cfg_vlmul == 3'b100)
               || (cfg_vsew > 3'd3)
               || (cfg_lsew > 5'(ELEN_LOG))
               || (cfg_frac && ((cfg_lsew + cfg_frac_sh) > 5'(ELEN_LOG)))
               || (|pend_vtype_q[XLEN-2:8]);

        cfg_base = VLEN_X >> cfg_lsew;
        if (cfg_ill) begin
            cfg_vlmax = '0;
        end else if (cfg_frac) begin
            cfg_vlmax = cfg_base >> cfg_frac_sh;
        end else begin
            cfg_vlmax = cfg_base << cfg_vlmul[1:0];
        end

        if (cfg_ill) begin
            cfg_vl = '0;
        end else if (pend_ivli_q || !pend_rs1_zero_q) begin
            cfg_vl = (pend_src_q < cfg_vlmax) ? pend_src_q : cfg_vlmax;
        end else if (!pend_rd_zero_q) begin
            cfg_vl = cfg_vlmax;
        end else begin
            cfg_vl = (vl_q < cfg_vlmax) ? vl_q : cfg_vlmax;
        end

        cfg_vtype = cfg_ill ? VILL_VTYPE : XLEN'(pend_vtype_q[7:0]);
    end

    // ------------------------------------------------------------------
    // Architectural state and response next values
    // ------------------------------------------------------------------
    always_comb begin
        vtype_d         = vtype_q;
        vl_d            = vl_q;
        vlmax_d         = vlmax_q;
        vstart_d        = vstart_q;
        vxrm_d          = vxrm_q;
        // Saturation is sticky; an explicit CSR write below overrides it.
        vxsat_d         = vxsat_q | vxsat_set;
        resp_data_d     = resp_data_q;
        resp_illegal_d  = resp_illegal_q;
        pend_ivli_d     = pend_ivli_q;
        pend_rs1_zero_d = pend_rs1_zero_q;
        pend_rd_zero_d  = pend_rd_zero_q;
        pend_src_d      = pend_src_q;
        pend_vtype_d    = pend_vtype_q;

        if (accept_cfg) begin
            pend_ivli_d     = (req_kind == 2'b10);
            pend_rs1_zero_d = (req_rs1_addr == 5'd0);
            pend_rd_zero_d  = (req_rd_addr == 5'd0);
            pend_src_d      = req_src;
            pend_vtype_d    = req_vtype[XLEN-2:0];
        end

        if (accept_csr) begin
            resp_illegal_d = csr_illegal;
            resp_data_d    = csr_illegal ? '0 : csr_old;
            if (!csr_illegal) begin
                case (req_csr_addr)
                    CSR_VSTART: vstart_d = csr_new[VSTART_W-1:0];
                    CSR_VXSAT:  vxsat_d  = csr_new[0];
                    CSR_VXRM:   vxrm_d   = csr_new[1:0];
                    CSR_VCSR: begin
                        vxrm_d  = csr_new[2:1];
                        vxsat_d = csr_new[0];
                    end
                    default: ;
                endcase
            end
        end

        if (commit_cfg) begin
            vtype_d        = cfg_vtype;
            vl_d           = cfg_vl;
            vlmax_d        = cfg_vlmax;
            vstart_d       = '0;
            resp_data_d    = cfg_vl;
            resp_illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vtype_q         <= VILL_VTYPE;
            vl_q            <= '0;
            vlmax_q         <= '0;
            vstart_q        <= '0;
            vxrm_q          <= '0;
            vxsat_q         <= 1'b0;
            resp_data_q     <= '0;
            resp_illegal_q  <= 1'b0;
            pend_ivli_q     <= 1'b0;
            pend_rs1_zero_q <= 1'b0;
            pend_rd_zero_q  <= 1'b0;
            pend_src_q      <= '0;
            pend_vtype_q    <= '0;
        end else begin
            vtype_q         <= vtype_d;
            vl_q            <= vl_d;
            vlmax_q         <= vlmax_d;
            vstart_q        <= vstart_d;
            vxrm_q          <= vxrm_d;
            vxsat_q         <= vxsat_d;
            resp_data_q     <= resp_data_d;
            resp_illegal_q  <= resp_illegal_d;
            pend_ivli_q     <= pend_ivli_d;
            pend_rs1_zero_q <= pend_rs1_zero_d;
            pend_rd_zero_q  <= pend_rd_zero_d;
            pend_src_q      <= pend_src_d;
            pend_vtype_q    <= pend_vtype_d;
        end
    end

    assign resp_data    = resp_data_q;
    assign resp_illegal = resp_illegal_q;
    assign vtype_o      = vtype_q;
    assign vl_o         = vl_q;
    assign vstart_o     = XLEN'(vstart_q);
    assign vlmax_o      = vlmax_q;
    // vtype_q only ever holds a legal vsew (0..3) or the all-zero vill form.
    assign sew_o        = 7'd8 << vtype_q[4:3];
    assign vxrm_o       = vxrm_q;
    assign vill_o       = vtype_q[XLEN-1];

endmodule

// File: tb/tb_vec_csr_ctrl.sv
// tb_vec_csr_ctrl: directed self-checking bench for vec_csr_ctrl
// (XLEN=32, VLEN=512, ELEN=64). Inputs change on the falling edge and
// outputs are sampled 1 time unit after the rising edge.
module tb_vec_csr_ctrl;

    logic        clk;
    logic        n_rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr_addr;
    logic [4:0]  req_rs1_addr;
    logic [4:0]  req_rd_addr;
    logic [31:0] req_src;
    logic [31:0] req_vtype;
    logic        vec_idle;
    logic        vxsat_set;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_illegal;
    logic [31:0] vtype_o;
    logic [31:0] vl_o;
    logic [31:0] vstart_o;
    logic [31:0] vlmax_o;
    logic [6:0]  sew_o;
    logic [1:0]  vxrm_o;
    logic        vill_o;

    int checks = 0;
    int errors = 0;

    vec_csr_ctrl #(
        .XLEN(32),
        .VLEN(512),
        .ELEN(64)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_kind    (req_kind),
        .req_funct3  (req_funct3),
        .req_csr_addr(req_csr_addr),
        .req_rs1_addr(req_rs1_addr),
        .req_rd_addr (req_rd_addr),
        .req_src     (req_src),
        .req_vtype   (req_vtype),
        .vec_idle    (vec_idle),
        .vxsat_set   (vxsat_set),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_illegal(resp_illegal),
        .vtype_o     (vtype_o),
        .vl_o        (vl_o),
        .vstart_o    (vstart_o),
        .vlmax_o     (vlmax_o),
        .sew_o       (sew_o),
        .vxrm_o      (vxrm_o),
        .vill_o      (vill_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single accept edge; returns 1 unit after it.
    task automatic applyStimulus(input logic [1:0] kind, input logic [2:0] f3,
                                 input logic [11:0] addr, input logic [4:0] rs1,
                                 input logic [4:0] rd, input logic [31:0] src,
                                 input logic [31:0] vt);
        @(negedge clk);
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_kind     = kind;
        req_funct3   = f3;
        req_csr_addr = addr;
        req_rs1_addr = rs1;
        req_rd_addr  = rd;
        req_src      = src;
        req_vtype    = vt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        vxsat_set = 1'b0;
    endtask

    task automatic waitResp(input int max_cycles, output int cycles);
        cycles = 0;
        while (resp_valid !== 1'b1 && cycles < max_cycles) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic runCsr(input string tag, input logic [2:0] f3,
                          input logic [11:0] addr, input logic [4:0] rs1,
                          input logic [31:0] src, input logic [31:0] exp_data,
                          input logic exp_ill);
        applyStimulus(2'b00, f3, addr, rs1, 5'd1, src, 32'd0);
        checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        checkOutput({tag, "_resp_data"}, resp_data, exp_data);
        checkOutput({tag, "_resp_illegal"}, 32'(resp_illegal), 32'(exp_ill));
        @(posedge clk);
        #1;
        checkOutput({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic runConfig(input string tag, input logic [1:0] kind,
                             input logic [4:0] rs1, input logic [4:0] rd,
                             input logic [31:0] src, input logic [31:0] vt,
                             input logic [31:0] exp_vl);
        int cyc;
        applyStimulus(kind, 3'b111, 12'h000, rs1, rd, src, vt);
        checkOutput({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
        waitResp(10, cyc);
        checkOutput({tag, "_latency"}, 32'(cyc), 32'd1);
        checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        checkOutput({tag, "_resp_data"}, resp_data, exp_vl);
        checkOutput({tag, "_resp_illegal"}, 32'(resp_illegal), 32'd0);
        checkOutput({tag, "_vl"}, vl_o, exp_vl);
        @(posedge clk);
        #1;
        checkOutput({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        n_rst        = 1'b0;
        req_valid    = 1'b0;
        req_kind     = 2'b00;
        req_funct3   = 3'b000;
        req_csr_addr = 12'h000;
        req_rs1_addr = 5'd0;
        req_rd_addr  = 5'd0;
        req_src      = 32'd0;
        req_vtype    = 32'd0;
        vec_idle     = 1'b1;
        vxsat_set    = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_vtype", vtype_o, 32'h8000_0000);
        checkOutput("rst_vill", 32'(vill_o), 32'd1);
        checkOutput("rst_vl", vl_o, 32'd0);
        checkOutput("rst_vstart", vstart_o, 32'd0);
        checkOutput("rst_vlmax", vlmax_o, 32'd0);
        checkOutput("rst_vxrm", 32'(vxrm_o), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        checkOutput("rst_resp_illegal", 32'(resp_illegal), 32'd0);
        n_rst = 1'b1;

        // vsetvli AVL=100, SEW32 LMUL1 -> VLMAX 16
        runConfig("vsetvli_avl", 2'b01, 5'd1, 5'd2, 32'd100, 32'h010, 32'd16);
        checkOutput("avl_vlmax", vlmax_o, 32'd16);
        checkOutput("avl_sew", 32'(sew_o), 32'd32);
        checkOutput("avl_vtype", vtype_o, 32'h010);
        checkOutput("avl_vill", 32'(vill_o), 32'd0);

        // rs1=x0, rd!=x0: vl = VLMAX (SEW8 LMUL8 -> 512)
        runConfig("vsetvli_max", 2'b01, 5'd0, 5'd5, 32'hdead, 32'h003, 32'd512);
        checkOutput("max_vlmax", vlmax_o, 32'd512);
        checkOutput("max_sew", 32'(sew_o), 32'd8);

        // CSR accesses
        runCsr("vstart_wr", 3'b001, 12'h008, 5'd2, 32'h25, 32'd0, 1'b0);
        checkOutput("vstart_val", vstart_o, 32'h25);
        runCsr("vl_rs_bad", 3'b010, 12'hC20, 5'd3, 32'h1, 32'd0, 1'b1);
        checkOutput("vl_kept", vl_o, 32'd512);
        runCsr("vl_read", 3'b010, 12'hC20, 5'd0, 32'h0, 32'd512, 1'b0);
        runCsr("vstart_trunc", 3'b001, 12'h008, 5'd2, 32'hABC, 32'h25, 1'b0);
        checkOutput("vstart_trunc_val", vstart_o, 32'h0BC);
        runCsr("vlenb_read", 3'b010, 12'hC22, 5'd0, 32'h0, 32'd64, 1'b0);
        runCsr("vtype_wr_bad", 3'b001, 12'hC21, 5'd1, 32'h5, 32'd0, 1'b1);
        checkOutput("vtype_kept", vtype_o, 32'h003);
        runCsr("unknown_addr", 3'b001, 12'h123, 5'd1, 32'h5, 32'd0, 1'b1);
        runCsr("funct3_100", 3'b100, 12'h008, 5'd1, 32'h5, 32'd0, 1'b1);
        checkOutput("vstart_kept", vstart_o, 32'h0BC);

        // Reserved vlmul -> vill, vl=0, vstart cleared
        runConfig("vill_lmul", 2'b01, 5'd1, 5'd1, 32'd10, 32'h004, 32'd0);
        checkOutput("vill_flag", 32'(vill_o), 32'd1);
        checkOutput("vill_vtype", vtype_o, 32'h8000_0000);
        checkOutput("vill_vlmax", vlmax_o, 32'd0);
        checkOutput("vill_vstart", vstart_o, 32'd0);

        // vxsat: write priority over concurrent saturation, then stickiness
        runCsr("vxsat_wi", 3'b101, 12'h009, 5'd1, 32'h1, 32'd0, 1'b0);
        vxsat_set = 1'b1;
        runCsr("vxsat_rc", 3'b011, 12'h009, 5'd1, 32'h1, 32'd1, 1'b0);
        runCsr("vxsat_rd0", 3'b010, 12'h009, 5'd0, 32'h0, 32'd0, 1'b0);
        @(negedge clk);
        vxsat_set = 1'b1;
        @(negedge clk);
        vxsat_set = 1'b0;
        runCsr("vxsat_rd1", 3'b010, 12'h009, 5'd0, 32'h0, 32'd1, 1'b0);

        // vcsr packs {vxrm, vxsat}
        runCsr("vcsr_wr", 3'b001, 12'h00F, 5'd4, 32'h5, 32'd1, 1'b0);
        checkOutput("vcsr_vxrm", 32'(vxrm_o), 32'd2);
        runCsr("vcsr_rd", 3'b010, 12'h00F, 5'd0, 32'h0, 32'd5, 1'b0);

        // vsetivli held off by a busy pipeline for 5 cycles
        vec_idle = 1'b0;
        applyStimulus(2'b10, 3'b111, 12'h000, 5'd31, 5'd3, 32'd31, 32'h008);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_ready", 32'(req_ready), 32'd0);
            checkOutput("stall_resp", 32'(resp_valid), 32'd0);
            checkOutput("stall_vl", vl_o, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        vec_idle = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall_resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("stall_resp_data", resp_data, 32'd31);
        checkOutput("stall_vl_commit", vl_o, 32'd31);
        checkOutput("stall_vlmax", vlmax_o, 32'd32);
        checkOutput("stall_sew", 32'(sew_o), 32'd16);
        @(posedge clk);
        #1;
        checkOutput("stall_resp_drop", 32'(resp_valid), 32'd0);

        // rs1=x0, rd=x0 keeps min(old vl, VLMAX)
        runConfig("keep_shrink", 2'b01, 5'd0, 5'd0, 32'd0, 32'h018, 32'd8);
        checkOutput("keep_shrink_vlmax", vlmax_o, 32'd8);
        runConfig("keep_grow", 2'b01, 5'd0, 5'd0, 32'd0, 32'h008, 32'd8);
        checkOutput("keep_grow_vlmax", vlmax_o, 32'd32);

        // vsetvl with fractional LMUL 1/2, SEW16 -> VLMAX 16
        runConfig("vsetvl_frac", 2'b11, 5'd7, 5'd1, 32'd1000, 32'h00F, 32'd16);
        checkOutput("frac_vlmax", vlmax_o, 32'd16);
        checkOutput("frac_vtype", vtype_o, 32'h00F);

        // SEW64 with LMUL 1/2 exceeds ELEN*LMUL
        runConfig("vill_frac", 2'b01, 5'd7, 5'd1, 32'd5, 32'h01F, 32'd0);
        checkOutput("vill_frac_flag", 32'(vill_o), 32'd1);

        runConfig("ta_ma", 2'b01, 5'd7, 5'd1, 32'd5, 32'h0D0, 32'd5);
        checkOutput("ta_ma_vtype", vtype_o, 32'h0D0);

        // Reserved high vtype bit set
        runConfig("vill_hibit", 2'b01, 5'd7, 5'd1, 32'd5, 32'h110, 32'd0);
        checkOutput("vill_hibit_vtype", vtype_o, 32'h8000_0000);

        // Reset while waiting for the pipeline abandons the request
        vec_idle = 1'b0;
        applyStimulus(2'b01, 3'b111, 12'h000, 5'd1, 5'd1, 32'd100, 32'h010);
        checkOutput("abort_wait_ready", 32'(req_ready), 32'd0);
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("abort_ready", 32'(req_ready), 32'd1);
        checkOutput("abort_vxrm", 32'(vxrm_o), 32'd0);
        checkOutput("abort_vtype", vtype_o, 32'h8000_0000);
        @(negedge clk);
        n_rst    = 1'b1;
        vec_idle = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        checkOutput("abort_vl", vl_o, 32'd0);
        checkOutput("abort_vill", 32'(vill_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
